// File: rtl/bat_program_loader.sv
// BatAmateur program loader: parses a segmented image from a valid/ready stream,
// writes each segment through a dedicated memory port and holds the CPU halted until the terminator.
module bat_program_loader #(
   parameter int DATA_WIDTH    = 16,
   parameter int ADDRESS_WIDTH = 16
) (
   input  logic                     CLK,
   input  logic                     RESET_N,
   input  logic                     START,
   input  logic [DATA_WIDTH-1:0]    IN_DATA,
   input  logic                     IN_VALID,
   output logic                     IN_READY,
   output logic                     MEM_WE,
   output logic [ADDRESS_WIDTH-1:0] MEM_ADDRESS,
   output logic [DATA_WIDTH-1:0]    MEM_DATA,
   output logic                     HALT,
   output logic [ADDRESS_WIDTH-1:0] ENTRY_ADDRESS,
   output logic                     DONE,
   output logic                     ERROR,
   output logic [DATA_WIDTH-1:0]    WORDS_LOADED
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_GET_ADDR,
      S_GET_COUNT,
      S_DATA,
      S_GET_CSUM,
      S_RUN,
      S_ERROR
   } state_t;

   state_t                   state;
   logic [ADDRESS_WIDTH-1:0] ptr;
   logic [DATA_WIDTH-1:0]    remaining;
   logic [DATA_WIDTH-1:0]    sum;
   logic [ADDRESS_WIDTH-1:0] hdr_addr;
   logic [DATA_WIDTH-1:0]    csum_total;
   logic                     xfer;

   // Header address words are truncated (or zero-extended) to the memory address width.
   generate
      if (ADDRESS_WIDTH <= DATA_WIDTH) begin : g_addr_trunc
         assign hdr_addr = IN_DATA[ADDRESS_WIDTH-1:0];
      end else begin : g_addr_ext
         assign hdr_addr = {{(ADDRESS_WIDTH-DATA_WIDTH){1'b0}}, IN_DATA};
      end
   endgenerate

   assign IN_READY   = (state == S_GET_ADDR) || (state == S_GET_COUNT) ||
                       (state == S_DATA)     || (state == S_GET_CSUM);
   assign xfer       = IN_VALID && IN_READY;
   assign csum_total = sum + IN_DATA;

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state         <= S_IDLE;
         ptr           <= '0;
         remaining     <= '0;
         sum           <= '0;
         MEM_WE        <= 1'b0;
         MEM_ADDRESS   <= '0;
         MEM_DATA      <= '0;
         HALT          <= 1'b1;
         ENTRY_ADDRESS <= '0;
         DONE          <= 1'b0;
         ERROR         <= 1'b0;
         WORDS_LOADED  <= '0;
      end else begin
         MEM_WE <= 1'b0;
         case (state)
            S_IDLE, S_RUN, S_ERROR: begin
               if (START) begin
                  state        <= S_GET_ADDR;
                  HALT         <= 1'b1;
                  DONE         <= 1'b0;
                  ERROR        <= 1'b0;
                  WORDS_LOADED <= '0;
               end
            end
            S_GET_ADDR: begin
               if (xfer) begin
                  ptr   <= hdr_addr;
                  sum   <= '0;
                  state <= S_GET_COUNT;
               end
            end
            S_GET_COUNT: begin
               if (xfer) begin
                  remaining <= IN_DATA;
                  if (IN_DATA == '0) begin
                     // Terminator: its address word is the entry point.
                     ENTRY_ADDRESS <= ptr;
                     HALT          <= 1'b0;
                     DONE          <= 1'b1;
                     state         <= S_RUN;
                  end else begin
                     state <= S_DATA;
                  end
               end
            end
            S_DATA: begin
               if (xfer) begin
                  MEM_WE       <= 1'b1;
                  MEM_ADDRESS  <= ptr;
                  MEM_DATA     <= IN_DATA;
                  ptr          <= ptr + ADDRESS_WIDTH'(1);
                  sum          <= csum_total;
                  remaining    <= remaining - DATA_WIDTH'(1);
                  WORDS_LOADED <= WORDS_LOADED + DATA_WIDTH'(1);
                  if (remaining == DATA_WIDTH'(1))
                     state <= S_GET_CSUM;
               end
            end
            S_GET_CSUM: begin
               if (xfer) begin
                  if (csum_total == '0) begin
                     state <= S_GET_ADDR;
                  end else begin
                     ERROR <= 1'b1;
                     state <= S_ERROR;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
